// File: rtl/lc3b_types.sv
// Shared LC-3b out-of-order core types: ROB tags, data words and the common data bus payload.
package lc3b_types;

    localparam int unsigned ROB_ADDR_W  = 3;
    localparam int unsigned WORD_W      = 16;
    localparam int unsigned CDB_NUM_REQ = 4;

    typedef logic [ROB_ADDR_W-1:0] lc3b_rob_addr;
    typedef logic [WORD_W-1:0]     lc3b_word;

    typedef struct packed {
        logic         valid;
        lc3b_rob_addr tag;
        lc3b_word     value;
    } lc3b_cdb;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: scans upward from ptr with wrap, first request wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any_grant
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    // Explicit modulo keeps non-power-of-two requester counts correct.
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand     = (32'(ptr) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (enable && !any_grant && req[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
                any_grant       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among result producers, registered CDB broadcast.
module cdb_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned NUM_REQ = CDB_NUM_REQ,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [NUM_REQ-1:0] req,
    input  lc3b_rob_addr       req_tag   [NUM_REQ],
    input  lc3b_word           req_value [NUM_REQ],
    output logic [NUM_REQ-1:0] grant,
    output lc3b_cdb            CDB_out,
    output logic [IDX_W-1:0]   prio_ptr
);

    logic [IDX_W-1:0] win_idx;
    logic             any_grant;
    logic [IDX_W-1:0] ptr_next;
    lc3b_rob_addr     sel_tag;
    lc3b_word         sel_value;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (req),
        .ptr       (prio_ptr),
        .enable    (!flush),
        .grant     (grant),
        .idx       (win_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        sel_tag   = req_tag[win_idx];
        sel_value = req_value[win_idx];
        ptr_next  = (32'(win_idx) == NUM_REQ - 1) ? '0 : IDX_W'(32'(win_idx) + 1);
    end

    // Tag/value hold across idle cycles; only valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            CDB_out  <= '0;
            prio_ptr <= '0;
        end else if (flush) begin
            CDB_out.valid <= 1'b0;
            prio_ptr      <= '0;
        end else if (any_grant) begin
            CDB_out  <= '{valid: 1'b1, tag: sel_tag, value: sel_value};
            prio_ptr <= ptr_next;
        end else begin
            CDB_out.valid <= 1'b0;
        end
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Shares the single common data bus (CDB) among all result producers: three ALU reservation stations and the load buffer.
- Each cycle it picks at most one requester by rotating (round-robin) priority and returns a one-hot grant.
- It registers the winner's ROB tag and value onto CDB_out for the ROB, reservation stations and issue control.
- It replaces direct driving of the CDB by individual reservation stations.

## Interface
- NUM_REQ, 4, number of requesters; index 0-2 = ALU RS1-RS3, 3 = load buffer.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  pipeline flush (mispredict); synchronous.
- req  in  NUM_REQ  per-requester "result ready" request.
- req_tag  in  NUM_REQ x lc3b_rob_addr  ROB entry of each requester's result.
- req_value  in  NUM_REQ x lc3b_word  result value of each requester.
- grant  out  NUM_REQ  one-hot combinational grant; all zero if none.
- CDB_out  out  CDB  registered broadcast {valid, tag, value}.
- prio_ptr  out  $clog2(NUM_REQ)  current highest-priority index (debug/verification).

## Operation
- Arbitration (combinational):
  - Scan from prio_ptr upward, wrapping at NUM_REQ-1 to 0.
  - The first index i with req[i]=1 wins and grant[i]=1.
  - grant is all-zero when req==0 or flush==1.
- Broadcast (registered):
  - On an edge with some grant[i]=1, CDB_out <= {1, req_tag[i], req_value[i]}.
  - Otherwise CDB_out.valid <= 0, with tag and value holding their last value.
- Pointer:
  - On an edge with grant[i]=1, prio_ptr <= (i+1) mod NUM_REQ.
  - With no grant, prio_ptr holds.
- Requester contract: a requester seeing grant[i]=1 at an edge treats its result as consumed and drops req[i] (or presents a new result) next cycle.
  - A req held high without a grant must keep tag and value stable.
- Flush:
  - No grant in a flush cycle.
  - Next edge: CDB_out.valid <= 0 and prio_ptr <= 0.
  - Requests pending during flush are not broadcast; the reservation stations clear themselves on the same flush.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 grants.

## Timing
- Reset (async, immediate): CDB_out = {0, 0, 16'h0000}, prio_ptr = 0.
  - grant follows req combinationally with pointer 0.
- Latency:
  - req to grant: 0 cycles (same cycle).
  - grant to CDB_out.valid: 1 cycle (next edge).
  - Exactly one broadcast per grant; at most one broadcast per cycle.
- Back-to-back: consecutive cycles may each grant, giving a continuous CDB_out.valid stream.
- Simultaneous events:
  - flush overrides req.
  - rst overrides everything, including in mid-cycle.
  - A result granted in the cycle before flush is still broadcast on the edge after that grant. Consumers discard it via their own flush handling.
- Wrap-around: a grant to index NUM_REQ-1 sets prio_ptr to 0.
- NUM_REQ must be at least 2; non-power-of-two values are legal, since the modulo is explicit and not a bit truncation.

## Structure
- The CDB struct {valid, tag, value}, lc3b_rob_addr and lc3b_word stay in the shared lc3b_types package.
- Add the constant for the default requester count to lc3b_types.
- Sub-module rr_arbiter:
  - Parameterized by NUM_REQ.
  - Inputs: req, ptr, enable. Outputs: one-hot grant, encoded winner index, any_grant.
  - Purely combinational, reusable for a future memory-port arbiter.
- Top level holds:
  - the prio_ptr register;
  - the CDB output register;
  - the tag/value select mux, indexed by the winner index.

## Test plan
- Reset:
  - Assert rst mid-cycle with CDB_out.valid=1 -> immediately CDB_out = {0, 0, 0} and prio_ptr=0.
- Single requester:
  - req=4'b0100, tag=3, value=16'h1234 -> grant=4'b0100 in the same cycle.
  - Next edge: CDB_out = {1, 3, 16'h1234}, prio_ptr=3.
- Rotation:
  - req=4'b1111 held for 4 cycles from ptr=0 -> grants 0001, 0010, 0100, 1000.
  - prio_ptr wraps 1, 2, 3, 0.
  - Each cycle's tag appears on CDB_out one cycle later.
- Skip/wrap:
  - ptr=3, req=4'b0011 -> grant=4'b0001, then ptr=1.
- Flush:
  - req=4'b1010, ptr=2, flush=1 -> grant=0.
  - Next edge: CDB_out.valid=0, prio_ptr=0.
  - Following cycle without flush: grant=4'b0010.
- Idle:
  - req=0 for 3 cycles after a broadcast -> CDB_out.valid=0, tag/value retained, prio_ptr unchanged.
